// File: rtl/alu_seq_pkg.sv
// Shared types for the sequenced accumulator ALU: opcodes, FSM states, ALU modes.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_HADD = 3'b001,
    OP_SUB  = 3'b010,
    OP_SHR  = 3'b011,
    OP_SHL  = 3'b100,
    OP_CLR  = 3'b101,
    OP_NOP  = 3'b110,
    OP_NOP2 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] MODE_HADD = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_SHL  = 2'b11;

  // Non-ALU opcodes map to HADD; their result is never selected.
  function automatic logic [1:0] op_to_mode(input op_e op);
    case (op)
      OP_HADD: return MODE_HADD;
      OP_SUB:  return MODE_SUB;
      OP_SHR:  return MODE_SHR;
      OP_SHL:  return MODE_SHL;
      default: return MODE_HADD;
    endcase
  endfunction

  // Only the shifts honour a repeat count.
  function automatic logic op_has_cnt(input op_e op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// Combinational 8-bit ALU: half-add, subtract, logical shift right/left.
module alu_seq_alu
  import alu_seq_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] mode,
  output logic [7:0] y
);

  // Result select; all arithmetic wraps mod 256.
  always_comb begin
    y = a;
    case (mode)
      MODE_HADD: y = {1'b0, a[7:1]} + b;
      MODE_SUB:  y = a - b;
      MODE_SHR:  y = {1'b0, a[7:1]};
      MODE_SHL:  y = {a[6:0], 1'b0};
      default:   y = a;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequenced accumulator ALU: accepts one command, iterates it cnt+1 times, pulses done.
// Optional sticky overflow flag is compiled in only when ALU_SEQ_OVF_EN is defined.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_vld,
  output logic       cmd_rdy,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic [2:0] cmd_cnt,
  output logic [7:0] acc,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  state_e     state_r;
  state_e     state_nxt_s;
  op_e        op_r;
  logic [7:0] data_r;
  logic [2:0] cnt_r;
  logic [7:0] acc_r;
  logic [7:0] acc_nxt_s;
  logic [7:0] alu_y_s;
  logic [1:0] mode_s;
  logic       accept_s;
  logic       last_s;
  logic       rdy_s;
  logic       busy_s;
  logic       done_s;

  assign accept_s = cmd_vld && rdy_s;
  assign last_s   = (cnt_r == 3'd0);
  assign mode_s   = op_to_mode(op_r);

  alu_seq_alu u_alu (
    .a    (acc_r),
    .b    (data_r),
    .mode (mode_s),
    .y    (alu_y_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = EXEC;
        else          state_nxt_s = IDLE;
      end
      EXEC: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = EXEC;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode, purely from the state register
  always_comb begin
    rdy_s  = 1'b0;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      IDLE:    rdy_s = 1'b1;
      EXEC:    busy_s = 1'b1;
      DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: rdy_s = 1'b0;
    endcase
  end

  // Accumulator next value: ALU ops take the ALU, others bypass it
  always_comb begin
    acc_nxt_s = acc_r;
    case (op_r)
      OP_LOAD: acc_nxt_s = data_r;
      OP_CLR:  acc_nxt_s = 8'h00;
      OP_HADD, OP_SUB, OP_SHR, OP_SHL: acc_nxt_s = alu_y_s;
      default: acc_nxt_s = acc_r;
    endcase
  end

  // Command latch and accumulator; count is forced to 0 for non-shift ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= 8'h00;
      op_r   <= OP_LOAD;
      data_r <= 8'h00;
      cnt_r  <= 3'd0;
    end else if (accept_s) begin
      op_r   <= op_e'(cmd_op);
      data_r <= cmd_data;
      cnt_r  <= op_has_cnt(op_e'(cmd_op)) ? cmd_cnt : 3'd0;
    end else if (state_r == EXEC) begin
      acc_r <= acc_nxt_s;
      if (!last_s) cnt_r <= cnt_r - 3'd1;
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic       ovf_r;
  logic       ovf_set_s;
  logic       ovf_clr_s;
  logic [8:0] hsum_s;

  assign hsum_s = {2'b00, acc_r[7:1]} + {1'b0, data_r};

  // Overflow set/clear conditions for the op in flight
  always_comb begin
    ovf_set_s = 1'b0;
    ovf_clr_s = 1'b0;
    case (op_r)
      OP_HADD: ovf_set_s = hsum_s[8];
      OP_SUB:  ovf_set_s = (acc_r < data_r);
      OP_SHL:  ovf_set_s = acc_r[7];
      OP_LOAD, OP_CLR: ovf_clr_s = 1'b1;
      default: ovf_set_s = 1'b0;
    endcase
  end

  // Sticky overflow flag, updated only on EXEC write edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (state_r == EXEC) begin
      if (ovf_clr_s)      ovf_r <= 1'b0;
      else if (ovf_set_s) ovf_r <= 1'b1;
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

  assign acc     = acc_r;
  assign cmd_rdy = rdy_s;
  assign busy    = busy_s;
  assign done    = done_s;

endmodule
